// File: rtl/apb_pkg.sv
// APB master shared types and defaults.
// Imported by the interface and the master.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam int APB_ADDR_W = 9;
    localparam int APB_DATA_W = 8;

    // The slave is chosen by the address MSB.
    function automatic int sel_bit(input int addr_w);
        return addr_w - 1;
    endfunction

    localparam int APB_SEL_BIT = sel_bit(APB_ADDR_W);

endpackage

// File: rtl/apb_master_if.sv
// Command/response and two-slave APB bus bundle.
// The master modport drives requests out to the APB slaves.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;
    logic              PSEL1_o;
    logic              PSEL2_o;
    logic              PENABLE_o;
    logic              PWRITE_o;
    logic [ADDR_W-1:0] PADDR_o;
    logic [DATA_W-1:0] PWDATA_o;
    logic [DATA_W-1:0] PRDATA1_i;
    logic [DATA_W-1:0] PRDATA2_i;
    logic              PREADY1_i;
    logic              PREADY2_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  PRDATA1_i, PRDATA2_i, PREADY1_i, PREADY2_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output PSEL1_o, PSEL2_o, PENABLE_o, PWRITE_o,
        output PADDR_o, PWDATA_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output PRDATA1_i, PRDATA2_i, PREADY1_i, PREADY2_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  PSEL1_o, PSEL2_o, PENABLE_o, PWRITE_o,
        input  PADDR_o, PWDATA_o
    );

endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master driving two slaves,
// with a bounded wait-state timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input logic          PCLK,
    input logic          PRESET_n,
    apb_master_if.master bus
);

    localparam int SB    = sel_bit(ADDR_W);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              cmd_ready;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              psel1;
    logic              psel2;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;

    always_comb begin
        sel_ready = bus.PREADY1_i;
        sel_rdata = bus.PRDATA1_i;
        if (paddr[SB]) begin
            sel_ready = bus.PREADY2_i;
            sel_rdata = bus.PRDATA2_i;
        end
    end

    assign cnt_nxt = wait_cnt + CNT_W'(1);

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            psel1     <= 1'b0;
            psel2     <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid_i && cmd_ready) begin
                        paddr     <= bus.cmd_addr_i;
                        pwdata    <= bus.cmd_wdata_i;
                        pwrite    <= bus.cmd_write_i;
                        // Decode now so PSEL is already valid in SETUP.
                        psel1     <= !bus.cmd_addr_i[SB];
                        psel2     <= bus.cmd_addr_i[SB];
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready || cnt_nxt == CNT_W'(TIMEOUT)) begin
                        psel1     <= 1'b0;
                        psel2     <= 1'b0;
                        penable   <= 1'b0;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !sel_ready;
                        rsp_rdata <= (sel_ready && !pwrite) ? sel_rdata : '0;
                        state     <= IDLE;
                    end
                    if (!sel_ready) begin
                        wait_cnt <= cnt_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_err_o   = rsp_err;
    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.PSEL1_o     = psel1;
    assign bus.PSEL2_o     = psel2;
    assign bus.PENABLE_o   = penable;
    assign bus.PWRITE_o    = pwrite;
    assign bus.PADDR_o     = paddr;
    assign bus.PWDATA_o    = pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: two memory slaves with programmable wait
// states, noise on the unselected PREADY, and a memory reference.
module tb_apb_master;
    import apb_pkg::*;

    localparam int TIMEOUT = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    apb_master_if #(.ADDR_W(9), .DATA_W(8)) bus ();

    apb_master #(.ADDR_W(9), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(clk),
        .PRESET_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave models
    int         wait1, wait2;
    int         acc1, acc2;
    bit         seeded;
    logic       noise1, noise2;
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    logic       rdy1, rdy2;

    assign rdy1 = bus.PSEL1_o && bus.PENABLE_o && (acc1 >= wait1);
    assign rdy2 = bus.PSEL2_o && bus.PENABLE_o && (acc2 >= wait2);
    assign bus.PREADY1_i = bus.PSEL1_o ? rdy1 : noise1;
    assign bus.PREADY2_i = bus.PSEL2_o ? rdy2 : noise2;
    assign bus.PRDATA1_i = mem1[bus.PADDR_o[7:0]];
    assign bus.PRDATA2_i = mem2[bus.PADDR_o[7:0]];

    always @(negedge clk) begin
        noise1 <= 1'($urandom);
        noise2 <= 1'($urandom);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc1 <= 0;
            acc2 <= 0;
            if (!seeded) begin
                for (int i = 0; i < 256; i++) begin
                    mem1[i] <= 8'(i * 37 + 1);
                    mem2[i] <= 8'(i * 11 + 100);
                end
            end
            seeded <= 1'b1;
        end else begin
            acc1 <= (bus.PSEL1_o && bus.PENABLE_o && !rdy1) ? acc1 + 1 : 0;
            acc2 <= (bus.PSEL2_o && bus.PENABLE_o && !rdy2) ? acc2 + 1 : 0;
            if (rdy1 && bus.PWRITE_o) mem1[bus.PADDR_o[7:0]] <= bus.PWDATA_o;
            if (rdy2 && bus.PWRITE_o) mem2[bus.PADDR_o[7:0]] <= bus.PWDATA_o;
        end
    end

    // Reference: what each slave should hold, from the transfers issued
    logic [7:0] ref_mem [2][256];

    function automatic int exp_lat(input int w);
        return (w >= TIMEOUT) ? TIMEOUT + 2 : w + 3;
    endfunction

    // Issue one transfer; report latency from acceptance, response,
    // bus protocol violations and whether SETUP preceded ACCESS.
    task automatic run_xfer(
        input  bit         wr,
        input  logic [8:0] a,
        input  logic [7:0] d,
        output int         lat,
        output logic [7:0] rd,
        output logic       er,
        output int         viol,
        output bit         ph_ok
    );
        int  guard;
        bit  got;
        bit  s2;
        logic sel, oth;
        viol = 0; ph_ok = 1; lat = 0; rd = '0; er = 1'b0;
        got = 0; guard = 0; s2 = a[8];
        @(negedge clk);
        while (!bus.cmd_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            viol++;
            lat = 999;
        end else begin
            bus.cmd_valid_i = 1'b1;
            bus.cmd_write_i = wr;
            bus.cmd_addr_i  = a;
            bus.cmd_wdata_i = d;
            @(posedge clk);
            #1;
            bus.cmd_valid_i = 1'b0;
            bus.cmd_write_i = 1'($urandom);
            bus.cmd_addr_i  = 9'($urandom);
            bus.cmd_wdata_i = 8'($urandom);
            while (!got && lat < 40) begin
                @(negedge clk);
                lat++;
                sel = s2 ? bus.PSEL2_o : bus.PSEL1_o;
                oth = s2 ? bus.PSEL1_o : bus.PSEL2_o;
                if (bus.rsp_valid_o) begin
                    got = 1;
                    rd  = bus.rsp_rdata_o;
                    er  = bus.rsp_err_o;
                    if (sel || oth || bus.PENABLE_o || !bus.cmd_ready_o) viol++;
                end else begin
                    if (oth || !sel || bus.cmd_ready_o) viol++;
                    if (bus.PADDR_o !== a || bus.PWRITE_o !== wr) viol++;
                    if (bus.PWDATA_o !== d) viol++;
                    if (lat == 1 && bus.PENABLE_o) ph_ok = 0;
                    if (lat >= 2 && !bus.PENABLE_o) ph_ok = 0;
                end
            end
            if (!got) lat = 999;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b1;
        bus.cmd_addr_i  = 9'h1AA;
        bus.cmd_wdata_i = 8'h55;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", bus.cmd_ready_o);
        end
        checks++;
        if ({bus.PSEL1_o, bus.PSEL2_o, bus.PENABLE_o, bus.PWRITE_o,
             bus.rsp_valid_o, bus.rsp_err_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                {bus.PSEL1_o, bus.PSEL2_o, bus.PENABLE_o, bus.PWRITE_o,
                 bus.rsp_valid_o, bus.rsp_err_o});
        end
        checks++;
        if ({bus.PADDR_o, bus.PWDATA_o, bus.rsp_rdata_o} !== 25'b0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h rdata %h want 0",
                bus.PADDR_o, bus.PWDATA_o, bus.rsp_rdata_o);
        end
        bus.cmd_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_xfer(
        input string name,
        input int lat, input int elat,
        input logic [7:0] rd, input logic [7:0] erd,
        input logic er, input logic eer,
        input int viol
    );
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
        end
        checks++;
        if (rd !== erd || er !== eer) begin
            errors++;
            $display("FAIL %s rsp: got rdata %h err %b want %h %b",
                name, rd, er, erd, eer);
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL %s bus: got %0d violations want 0", name, viol);
        end
    endtask

    task automatic test_slave1;
        int lat, viol; logic [7:0] rd; logic er; bit ph;
        wait1 = 1;
        run_xfer(1'b1, 9'h005, 8'hA5, lat, rd, er, viol, ph);
        ref_mem[0][5] = 8'hA5;
        check_xfer("wr_s1", lat, 4, rd, 8'h00, er, 1'b0, viol);
        checks++;
        if (!ph) begin
            errors++;
            $display("FAIL wr_s1 phase: got setup/access order bad want PSEL then PENABLE");
        end
        checks++;
        if (mem1[5] !== 8'hA5) begin
            errors++;
            $display("FAIL wr_s1 mem: got %h want a5", mem1[5]);
        end
        wait1 = 0;
        run_xfer(1'b0, 9'h005, 8'h00, lat, rd, er, viol, ph);
        check_xfer("rd_s1", lat, 3, rd, 8'hA5, er, 1'b0, viol);
    endtask

    task automatic test_slave2;
        int lat, viol; logic [7:0] rd; logic er; bit ph;
        wait2 = 2;
        run_xfer(1'b1, 9'h105, 8'h3C, lat, rd, er, viol, ph);
        ref_mem[1][5] = 8'h3C;
        check_xfer("wr_s2", lat, 5, rd, 8'h00, er, 1'b0, viol);
        wait2 = 1;
        run_xfer(1'b0, 9'h105, 8'h00, lat, rd, er, viol, ph);
        check_xfer("rd_s2", lat, 4, rd, 8'h3C, er, 1'b0, viol);
        checks++;
        if (mem1[5] !== 8'hA5 || mem2[5] !== 8'h3C) begin
            errors++;
            $display("FAIL s2_isolation: got s1 %h s2 %h want a5 3c",
                mem1[5], mem2[5]);
        end
    endtask

    task automatic test_timeout;
        int lat, viol; logic [7:0] rd; logic er; bit ph;
        wait1 = 99;
        run_xfer(1'b0, 9'h005, 8'h00, lat, rd, er, viol, ph);
        check_xfer("timeout", lat, TIMEOUT + 2, rd, 8'h00, er, 1'b1, viol);
        wait1 = 0;
        run_xfer(1'b0, 9'h005, 8'h00, lat, rd, er, viol, ph);
        check_xfer("after_timeout", lat, 3, rd, 8'hA5, er, 1'b0, viol);
    endtask

    task automatic test_reset_mid;
        int seen;
        wait2 = 99;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b1;
        bus.cmd_addr_i  = 9'h107;
        bus.cmd_wdata_i = 8'hEE;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (!(bus.PSEL2_o && bus.PENABLE_o)) begin
            errors++;
            $display("FAIL rstmid_access: got psel2 %b penable %b want 1 1",
                bus.PSEL2_o, bus.PENABLE_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.PSEL1_o, bus.PSEL2_o, bus.PENABLE_o, bus.rsp_valid_o,
             bus.cmd_ready_o} !== 5'b00001) begin
            errors++;
            $display("FAIL rstmid_drop: got %b want 00001",
                {bus.PSEL1_o, bus.PSEL2_o, bus.PENABLE_o, bus.rsp_valid_o,
                 bus.cmd_ready_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait2 = 0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.rsp_valid_o || bus.PSEL1_o || bus.PSEL2_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rstmid_quiet: got %0d active cycles want 0", seen);
        end
        checks++;
        if (mem2[7] !== ref_mem[1][7]) begin
            errors++;
            $display("FAIL rstmid_nowrite: got %h want %h", mem2[7], ref_mem[1][7]);
        end
    endtask

    task automatic test_random;
        int lat, viol, w, r; logic [7:0] rd, erd; logic er; bit ph, eer;
        bit wr; logic [8:0] a; logic [7:0] d;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom);
            a  = {1'($urandom), 8'($urandom_range(0, 7))};
            d  = 8'($urandom);
            r  = int'($urandom_range(0, 7));
            w  = (r == 0) ? 16 : (r == 1) ? 15 : int'($urandom_range(0, 3));
            if (a[8]) begin
                wait2 = w;
                wait1 = int'($urandom_range(0, 3));
            end else begin
                wait1 = w;
                wait2 = int'($urandom_range(0, 3));
            end
            eer = (w >= TIMEOUT);
            erd = (eer || wr) ? 8'h00 : ref_mem[a[8]][a[7:0]];
            run_xfer(wr, a, d, lat, rd, er, viol, ph);
            if (wr && !eer) ref_mem[a[8]][a[7:0]] = d;
            check_xfer("random", lat, exp_lat(w), rd, erd, er, eer, viol);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem1[i] !== ref_mem[0][i] || mem2[i] !== ref_mem[1][i]) begin
                errors++;
                $display("FAIL random_mem[%0d]: got %h %h want %h %h", i,
                    mem1[i], mem2[i], ref_mem[0][i], ref_mem[1][i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] ca [3];
        logic [7:0] cd [3];
        int acc_t [3];
        int rsp_t [3];
        int idx, nr, t, viol, guard;
        bit acc_now;
        ca[0] = 9'h010; ca[1] = 9'h111; ca[2] = 9'h012;
        for (int i = 0; i < 3; i++) begin
            cd[i] = 8'($urandom);
            acc_t[i] = -1;
            rsp_t[i] = -1;
        end
        wait1 = 1; wait2 = 1;
        idx = 0; nr = 0; t = 0; viol = 0; guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b1;
        bus.cmd_addr_i  = ca[0];
        bus.cmd_wdata_i = cd[0];
        while (nr < 3 && t < 60) begin
            acc_now = bus.cmd_ready_o && bus.cmd_valid_i;
            @(posedge clk);
            #1;
            if (acc_now) begin
                acc_t[idx] = t;
                idx++;
                if (idx < 3) begin
                    bus.cmd_addr_i  = ca[idx];
                    bus.cmd_wdata_i = cd[idx];
                end else begin
                    bus.cmd_valid_i = 1'b0;
                end
            end
            @(negedge clk);
            t++;
            if (bus.rsp_valid_o) begin
                rsp_t[nr] = t;
                nr++;
            end
            if ((bus.PSEL1_o || bus.PSEL2_o) && idx > 0 &&
                bus.PADDR_o !== ca[idx-1]) viol++;
        end
        bus.cmd_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_t[i] !== acc_t[i] + 4) begin
                errors++;
                $display("FAIL b2b_lat[%0d]: got rsp at %0d want %0d",
                    i, rsp_t[i], acc_t[i] + 4);
            end
            ref_mem[ca[i][8]][ca[i][7:0]] = cd[i];
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (acc_t[i+1] !== rsp_t[i]) begin
                errors++;
                $display("FAIL b2b_gap[%0d]: got accept at %0d want %0d",
                    i, acc_t[i+1], rsp_t[i]);
            end
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL b2b_addr: got %0d unstable cycles want 0", viol);
        end
        checks++;
        if (mem1[8'h10] !== cd[0] || mem2[8'h11] !== cd[1] ||
            mem1[8'h12] !== cd[2]) begin
            errors++;
            $display("FAIL b2b_mem: got %h %h %h want %h %h %h",
                mem1[8'h10], mem2[8'h11], mem1[8'h12], cd[0], cd[1], cd[2]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        seeded = 1'b0;
        wait1 = 0;
        wait2 = 0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[0][i] = 8'(i * 37 + 1);
            ref_mem[1][i] = 8'(i * 11 + 100);
        end
        test_reset();
        test_slave1();
        test_slave2();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning APB address width; bit ADDR_W-1 selects the slave.
REQ-002 SHALL have parameter DATA_W, default 8, meaning APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum ACCESS cycles to wait for PREADY.
REQ-004 PCLK  in  1  clock; all state changes on the rising edge.
REQ-005 PRESET_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid_i  in  1  a transfer request is present.
REQ-007 cmd_ready_o  out  1  the master can accept a request.
REQ-008 cmd_write_i  in  1  1 selects write, 0 selects read.
REQ-009 cmd_addr_i  in  ADDR_W  transfer address.
REQ-010 cmd_wdata_i  in  DATA_W  write data.
REQ-011 rsp_valid_o  out  1  one-cycle pulse marking transfer completion.
REQ-012 rsp_rdata_o  out  DATA_W  read data, valid with rsp_valid_o.
REQ-013 rsp_err_o  out  1  timeout flag, valid with rsp_valid_o.
REQ-014 PSEL1_o / PSEL2_o  out  1 each  slave selects.
REQ-015 PENABLE_o, PWRITE_o  out  1 each  APB phase signal and direction.
REQ-016 PADDR_o  out  ADDR_W  APB address.
REQ-017 PWDATA_o  out  DATA_W  APB write data.
REQ-018 PRDATA1_i / PRDATA2_i  in  DATA_W each  per-slave read data.
REQ-019 PREADY1_i / PREADY2_i  in  1 each  per-slave ready.

Function
REQ-020 SHALL implement a three-state FSM with states IDLE, SETUP and ACCESS.
REQ-021 cmd_ready_o SHALL be 1 only in IDLE; a request is accepted when cmd_valid_i and cmd_ready_o are both 1 at a rising edge.
REQ-022 On acceptance, the master SHALL register cmd_addr_i, cmd_wdata_i and cmd_write_i into PADDR_o, PWDATA_o and PWRITE_o, and SHALL enter SETUP.
REQ-023 In SETUP, the selected PSELx SHALL be 1 and PENABLE_o SHALL be 0; the FSM SHALL move unconditionally to ACCESS on the next edge.
REQ-024 In ACCESS, PSELx and PENABLE_o SHALL both be 1, and PADDR_o, PWDATA_o and PWRITE_o SHALL be held stable.
REQ-025 Slave select SHALL use the registered address: PADDR_o[ADDR_W-1]=0 selects slave 1 (PSEL1_o, PREADY1_i, PRDATA1_i); PADDR_o[ADDR_W-1]=1 selects slave 2.
REQ-026 The two PSEL outputs SHALL never be 1 together, and both SHALL be 0 in IDLE.
REQ-027 In ACCESS, when the selected PREADY is 1 at an edge, the master SHALL:
- capture the selected PRDATA into rsp_rdata_o on reads, or load 0 on writes;
- pulse rsp_valid_o for one cycle with rsp_err_o=0;
- return to IDLE.
REQ-028 The PREADY of the unselected slave SHALL be ignored.
REQ-029 Wait-state counter:
- cleared on entering ACCESS;
- incremented on each ACCESS edge with the selected PREADY at 0;
- on reaching TIMEOUT, the master SHALL abort to IDLE with rsp_valid_o=1, rsp_err_o=1 and rsp_rdata_o=0.
REQ-030 Latency with a slave that raises PREADY one cycle after PENABLE: acceptance at cycle N, SETUP at N+1, ACCESS at N+2 and N+3, rsp_valid_o and cmd_ready_o both 1 at N+4.
REQ-031 If PREADY is already 1 in the first ACCESS cycle, rsp_valid_o SHALL be 1 at N+3.
REQ-032 A request held on cmd_valid_i in the cycle rsp_valid_o pulses SHALL be accepted at that edge, giving back-to-back transfers with one IDLE cycle between them.
REQ-033 cmd_* inputs SHALL be ignored outside IDLE.
REQ-034 rsp_rdata_o SHALL hold its value until the next completion.

Reset
REQ-035 While PRESET_n is 0, all outputs SHALL be 0 except cmd_ready_o, which SHALL be 1; the FSM SHALL be in IDLE and the counter SHALL be 0.
REQ-036 Reset asserted mid-transfer SHALL immediately drop PSELx and PENABLE_o, and SHALL produce no response pulse.

Structure
REQ-037 Shared package apb_pkg SHALL hold:
- the state enum (IDLE, SETUP, ACCESS);
- default ADDR_W and DATA_W;
- the slave-select bit position.
REQ-038 The block SHALL be a single module with no sub-module; the decode and the counter are inline.

Verification
REQ-039 Write addr 0x005, data 0xA5, to slave 1 with 1-wait PREADY -> PSEL1_o then PENABLE_o; rsp_valid_o at N+4 with rsp_err_o=0; slave 1 location 5 holds 0xA5.
REQ-040 Read back addr 0x005 -> rsp_rdata_o=0xA5 with rsp_valid_o; PSEL2_o stays 0 throughout.
REQ-041 Write addr 0x105, data 0x3C, then read 0x105 -> only PSEL2_o is active; rsp_rdata_o=0x3C; slave 1 location 5 is still 0xA5.
REQ-042 Selected PREADY held at 0 -> after 16 ACCESS cycles, rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0; FSM returns to IDLE.
REQ-043 PRESET_n pulsed low during ACCESS -> PSELx, PENABLE_o and rsp_valid_o are 0 at once; cmd_ready_o=1; no response is produced after release.
REQ-044 cmd_valid_i held high for 3 writes -> three responses, one IDLE cycle between transfers, PADDR_o stable within each transfer.
